// File: rtl/alu_pkg.sv
// Shared definitions for the RV32M divide/remainder sequencer: op encodings,
// FSM state type and default datapath width.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: XLEN+1-bit trial subtract of |b| from the
// partial remainder shifted left by one quotient bit.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] babs,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next,
  output logic            qbit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, babs};
    qbit     = ~trial[XLEN];
    rem_next = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Sign conditioning and special cases live here; the bit loop is in div_step.
module alu_div_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  div_state_t      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] babs_q, babs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;

  logic            is_signed, is_rem;
  logic            a_neg, b_neg, overflow;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] step_rem, step_quo;
  logic            step_qbit;

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .babs     (babs_q),
    .rem_next (step_rem),
    .quo_next (step_quo),
    .qbit     (step_qbit)
  );

  always_comb begin
    is_signed = ~op_q[0];
    is_rem    = op_q[1];
    a_neg     = is_signed & a_q[XLEN-1];
    b_neg     = is_signed & b_q[XLEN-1];
    a_abs     = a_neg ? -a_q : a_q;
    b_abs     = b_neg ? -b_q : b_q;
    // Most-negative / -1 would overflow the magnitude path.
    overflow  = is_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    babs_d   = babs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d = StPrep;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      StPrep: begin
        if (flush) begin
          state_d = StIdle;
        end else if (b_q == '0) begin
          result_d = is_rem ? a_q : '1;
          state_d  = StDone;
        end else if (overflow) begin
          result_d = is_rem ? '0 : a_q;
          state_d  = StDone;
        end else begin
          rem_d   = '0;
          quo_d   = a_abs;
          babs_d  = b_abs;
          cnt_d   = CW'(XLEN);
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = {step_quo[XLEN-1:1], step_qbit | step_quo[0]};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_rem) begin
            result_d = r_neg_q ? -rem_q : rem_q;
          end else begin
            result_d = q_neg_q ? -quo_q : quo_q;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      babs_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      babs_q   <= babs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Scoreboard bench for alu_div_sequencer: driver pushes expected result and
// done-cycle, an independent monitor pops and compares on every done pulse.
module tb_alu_div_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  alu_div_sequencer #(
    .XLEN(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc;
  logic [31:0] last_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: RISC-V M semantics from plain signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      DIV_OP_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return sx / sy;
      end
      DIV_OP_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_OP_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return sx % sy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called at a negedge: drive start for one edge, then record acceptance.
  task automatic issue_now(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    acc   = cyc;
    check("busy_after_start", {31'b0, busy}, 32'h1);
    if (push) begin
      e.res    = model(o, x, y);
      e.cyc    = acc + latency(o, x, y);
      last_exp = e.res;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: busy still %b want 0 after 60 cycles", busy);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    issue_now(o, x, y, 1'b1);
    wait_idle();
    check("result_held", result, last_exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with no pending op, result %h", result);
      end else begin
        e = sb.pop_front();
        check("done_result", result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    rst = 1'b0;

    run_op(DIV_OP_DIVU, 32'd100, 32'd7);
    run_op(DIV_OP_REMU, 32'd100, 32'd7);
    run_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_op(DIV_OP_DIV, 32'd5, 32'd0);
    run_op(DIV_OP_REMU, 32'd5, 32'd0);
    run_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush during CALC, then restart in the first idle cycle.
    @(negedge clk);
    issue_now(DIV_OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    issue_now(DIV_OP_DIVU, 32'd9, 32'd3, 1'b1);
    wait_idle();
    check("post_flush_result", result, 32'd3);

    // Flush and start together in IDLE: start dropped.
    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush_beats_start", {31'b0, busy}, 32'h0);

    // Reset mid-CALC with a concurrent start.
    @(negedge clk);
    issue_now(DIV_OP_DIV, 32'd12345, 32'd17, 1'b0);
    repeat (4) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", {31'b0, busy}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
